// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, state type and helpers for the tone player
package audio_pkg;

  localparam logic [7:0] PCM_MID = 8'd128;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Phase increments for C4..C6 at fs = 25e6/1024, inc = round(f*65536/fs); index 0 is silence.
  function automatic logic [15:0] tone_inc(input logic [3:0] sel);
    logic [15:0] inc;
    case (sel)
      4'd1:    inc = 16'd702;
      4'd2:    inc = 16'd788;
      4'd3:    inc = 16'd885;
      4'd4:    inc = 16'd937;
      4'd5:    inc = 16'd1052;
      4'd6:    inc = 16'd1181;
      4'd7:    inc = 16'd1326;
      4'd8:    inc = 16'd1405;
      4'd9:    inc = 16'd1577;
      4'd10:   inc = 16'd1770;
      4'd11:   inc = 16'd1875;
      4'd12:   inc = 16'd2105;
      4'd13:   inc = 16'd2362;
      4'd14:   inc = 16'd2651;
      4'd15:   inc = 16'd2809;
      default: inc = 16'd0;
    endcase
    return inc;
  endfunction

  // Square-wave PCM level: midscale when idle, otherwise midscale -/+ 4*vol by phase half.
  function automatic logic [7:0] pcm_level(input state_e st, input logic phase_msb,
                                           input logic [4:0] vol);
    logic [7:0] amp;
    amp = {1'b0, vol, 2'b00};
    if (st != PLAY) return PCM_MID;
    return phase_msb ? (PCM_MID + amp) : (PCM_MID - amp);
  endfunction

endpackage

// File: rtl/audio_pwm.sv
// rtl/audio_pwm.sv - 256-clock PWM of the current PCM sample
module audio_pwm
  import audio_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_i,
  output logic       pwm_o
);

  logic [7:0] pcnt_q;
  logic       pwm_q;

  // Free-running carrier counter and registered compare against the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= 8'd0;
      pwm_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_q + 8'd1;
      pwm_q  <= (pcnt_q < sample_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/audio_tone_player.sv
// rtl/audio_tone_player.sv - square-wave tone generator with linear volume decay
module audio_tone_player
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV    = 1024,
  parameter int DECAY_SAMPLES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audio_en,
  input  logic [3:0] audio_sel,
  input  logic [4:0] audio_vol,
  output logic       busy,
  output logic       done,
  output logic [7:0] sample_out,
  output logic       pwm_out
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int DW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_SAMPLES - 1);

  logic [CW-1:0] cnt_q;
  logic          tick;
  state_e        state_q;
  logic [15:0]   inc_q;
  logic [15:0]   phase_q;
  logic [4:0]    vol_q;
  logic [DW-1:0] dcnt_q;
  logic          done_q;
  logic [7:0]    sample_q;
  logic          cmd_load;

  assign tick     = (cnt_q == CNT_LAST);
  assign cmd_load = (audio_sel != 4'd0) && (audio_vol != 5'd0);

  // Sample-rate divider; runs regardless of state and ignores commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Play FSM: commands take priority over the tick, decay to zero ends the tone with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      inc_q   <= 16'd0;
      phase_q <= 16'd0;
      vol_q   <= 5'd0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (audio_en) begin
        if (cmd_load) begin
          state_q <= PLAY;
          inc_q   <= tone_inc(audio_sel);
          vol_q   <= audio_vol;
          phase_q <= 16'd0;
          dcnt_q  <= '0;
        end else begin
          state_q <= IDLE;
          vol_q   <= 5'd0;
        end
      end else if (state_q == PLAY && tick) begin
        phase_q <= phase_q + inc_q;
        if (dcnt_q == DCNT_LAST) begin
          dcnt_q <= '0;
          vol_q  <= vol_q - 5'd1;
          if (vol_q == 5'd1) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end else begin
          dcnt_q <= dcnt_q + DW'(1);
        end
      end
    end
  end

  // Registered PCM sample derived from the play state of the previous cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= PCM_MID;
    end else begin
      sample_q <= pcm_level(state_q, phase_q[15], vol_q);
    end
  end

  audio_pwm u_pwm (
    .clk      (clk),
    .reset    (reset),
    .sample_i (sample_q),
    .pwm_o    (pwm_out)
  );

  assign busy       = (state_q == PLAY);
  assign done       = done_q;
  assign sample_out = sample_q;

endmodule
